// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator and its receive-side
// checker.
// Contents:
//   chk_state_t  : checker FSM states (HUNT=0, VERIFY=1, LOCKED=2; 3 is illegal)
//   DEFAULT_TAPS : default feedback mask (8'hB8)
//   lfsr_next()  : one LFSR step. The generator and the checker both call it,
//                  so they always use the same polynomial.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

  // Shift left and insert the parity of the tapped bits at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] state,
                                           input logic [7:0] taps);
    return {state[6:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_prbs_checker_if.sv
// Received-word stream into the PRBS checker.
// Signals:
//   in_valid : in_bits carries a word this cycle
//   in_bits  : received 8-bit LFSR state word
// Handshake: valid-only, with no ready. The checker consumes every cycle where
// in_valid=1, and a beat is transferred on each rising edge with in_valid=1.
// When in_valid=0, in_bits is don't-care.
// Modports:
//   master : source (for example, the loopback path)
//   slave  : checker
interface lfsr_prbs_checker_if;
  logic       in_valid;
  logic [7:0] in_bits;

  modport master (output in_valid, output in_bits);
  modport slave  (input  in_valid, input  in_bits);
endinterface

// File: rtl/lfsr_popcount8.sv
// Combinational population count of an 8-bit word.
// Ports:
//   bits_i  [7:0] : word to count
//   count_o [3:0] : number of set bits (0..8)
module lfsr_popcount8 (
  input  logic [7:0] bits_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'd0, bits_i[i]};
    end
  end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Receive-side checker for the 8-bit LFSR pattern generator.
// It seeds itself from a received word, verifies LOCK_COUNT consecutive
// predictions, and then free-runs (flywheels) its own LFSR. In that mode it
// counts errors and drops lock after LOSS_COUNT consecutive misses.
//
// Ports:
//   clk        : clock; all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   rx         : received word stream (slave modport: in_valid, in_bits)
//   clear_cnt  : synchronous clear of err_count; wins over a simultaneous error
//   locked     : checker is in LOCKED
//   err_pulse  : one-cycle pulse per mismatched beat while LOCKED
//   err_count  : saturating error count (CNT_W bits)
//   chk_state  : current FSM state (debug)
//
// Build option:
//   LFSR_CHK_BITERR_EN
//     Defined:   err_count adds popcount(in_bits ^ pred), counting bit errors.
//     Undefined: err_count adds 1 per mismatched word.
//
// All outputs are registered.
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter logic [7:0] TAPS       = DEFAULT_TAPS,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 3,
  parameter int         CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lfsr_prbs_checker_if.slave   rx,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     err_count,
  output logic [1:0]           chk_state
);

  localparam int MATCH_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = (LOSS_COUNT < 2) ? 1 : $clog2(LOSS_COUNT + 1);

  chk_state_t         state_q, state_d;
  logic [7:0]         pred_q, pred_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic [MATCH_W-1:0] match_inc;
  logic [MISS_W-1:0]  miss_inc;
  logic [CNT_W-1:0]   err_inc;
  logic [CNT_W:0]     err_sum;
  logic [CNT_W-1:0]   err_sat;
  logic               word_match;
  logic               word_zero;

  assign match_inc  = match_q + MATCH_W'(1);
  assign miss_inc   = miss_q + MISS_W'(1);
  assign word_match = (rx.in_bits == pred_q);
  assign word_zero  = (rx.in_bits == 8'h00);

`ifdef LFSR_CHK_BITERR_EN
  logic [3:0] bit_errs;

  lfsr_popcount8 u_popcount (
    .bits_i  (rx.in_bits ^ pred_q),
    .count_o (bit_errs)
  );

  assign err_inc = CNT_W'(bit_errs);
`else
  assign err_inc = CNT_W'(1);
`endif

  // Saturating add: a carry out of the top bit pins the count at all-ones.
  assign err_sum = {1'b0, err_count_q} + {1'b0, err_inc};
  assign err_sat = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      HUNT: begin
        // An all-zero word is the LFSR lockup state and cannot seed.
        if (rx.in_valid && !word_zero) begin
          pred_d  = lfsr_next(rx.in_bits, TAPS);
          match_d = '0;
          state_d = VERIFY;
        end
      end

      VERIFY: begin
        if (rx.in_valid) begin
          if (word_match) begin
            pred_d  = lfsr_next(rx.in_bits, TAPS);
            match_d = match_inc;
            if (match_inc == MATCH_W'(LOCK_COUNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else if (!word_zero) begin
            // Assume a false seed and re-seed from this word.
            pred_d  = lfsr_next(rx.in_bits, TAPS);
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = HUNT;
          end
        end
      end

      LOCKED: begin
        if (rx.in_valid) begin
          // Flywheel: the prediction advances from itself, never from input,
          // so a corrupted word cannot pull the checker off the sequence.
          pred_d = lfsr_next(pred_q, TAPS);
          if (!word_match) begin
            err_pulse_d = 1'b1;
            err_count_d = err_sat;
            miss_d      = miss_inc;
            if (miss_inc == MISS_W'(LOSS_COUNT)) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              miss_d   = '0;
              match_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
      end

      default: begin
        // Illegal encoding: recover to HUNT.
        state_d  = HUNT;
        locked_d = 1'b0;
        match_d  = '0;
        miss_d   = '0;
      end
    endcase

    if (clear_cnt) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      pred_q      <= 8'h00;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign chk_state = state_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker.
// Two checker instances share one input stream: CNT_W=16 and CNT_W=4. The
// narrow instance shows counter saturation.
module tb_lfsr_prbs_checker;

  localparam int ST_HUNT   = 0;
  localparam int ST_VERIFY = 1;
  localparam int ST_LOCKED = 2;

  // First error count after lock: the word 55 arrives where 23 is expected.
`ifdef LFSR_CHK_BITERR_EN
  localparam logic [15:0] E2 = 16'd5;
`else
  localparam logic [15:0] E2 = 16'd1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [1:0]  chk_state;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;
  logic [1:0]  chk_state4;

  int checks = 0;
  int errors = 0;

  lfsr_prbs_checker_if rx_if ();

  lfsr_prbs_checker #(.CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx_if),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .chk_state (chk_state)
  );

  lfsr_prbs_checker #(.CNT_W(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx_if),
    .clear_cnt (clear_cnt),
    .locked    (locked4),
    .err_pulse (err_pulse4),
    .err_count (err_count4),
    .chk_state (chk_state4)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [7:0]  bits;
    logic        clear;
    logic        exp_locked;
    logic        exp_pulse;
    logic [15:0] exp_count;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[$];
  logic [19:0] exp_q[$];  // {locked, pulse, state, count}

  // Bench-side LFSR step with taps 7, 5, 4 and 3.
  function automatic logic [7:0] nx(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  function automatic logic [3:0] sat4(input logic [15:0] k);
    return (k > 16'd15) ? 4'd15 : k[3:0];
  endfunction

  task automatic add(input logic v, input logic [7:0] b, input logic c,
                     input logic el, input logic ep, input logic [15:0] ec,
                     input int es);
    vec_t t;
    t.valid = v; t.bits = b; t.clear = c;
    t.exp_locked = el; t.exp_pulse = ep; t.exp_count = ec;
    t.exp_state = 2'(es);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic el, input logic ep,
                           input logic [15:0] ec, input logic [1:0] es);
    check({tag, " locked"},    32'(locked),     32'(el));
    check({tag, " err_pulse"}, 32'(err_pulse),  32'(ep));
    check({tag, " err_count"}, 32'(err_count),  32'(ec));
    check({tag, " chk_state"}, 32'(chk_state),  32'(es));
    check({tag, " count4"},    32'(err_count4), 32'(sat4(ec)));
    check({tag, " locked4"},   32'(locked4),    32'(el));
  endtask

  // Driver: apply one beat at the falling edge, then sample 1 ns after the
  // next rising edge.
  task automatic beat(input logic v, input logic [7:0] b, input logic c);
    @(negedge clk);
    rx_if.in_valid = v;
    rx_if.in_bits  = b;
    clear_cnt      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_beat(input logic v, input logic [7:0] b);
    @(negedge clk);
    rst            = 1'b1;
    rx_if.in_valid = v;
    rx_if.in_bits  = b;
    clear_cnt      = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  p;
    logic [15:0] k;
    logic [19:0] e;

    rst = 1'b1; clear_cnt = 1'b0;
    rx_if.in_valid = 1'b0; rx_if.in_bits = 8'h00;

    // Lock on 01,02,04,08,11, take one error, then recover.
    add(1, 8'h01, 0, 0, 0, 0,  ST_VERIFY);
    add(1, 8'h02, 0, 0, 0, 0,  ST_VERIFY);
    add(1, 8'h04, 0, 0, 0, 0,  ST_VERIFY);
    add(1, 8'h08, 0, 0, 0, 0,  ST_VERIFY);
    add(1, 8'h11, 0, 1, 0, 0,  ST_LOCKED);
    add(1, 8'h55, 0, 1, 1, E2, ST_LOCKED);
    add(1, 8'h47, 0, 1, 0, E2, ST_LOCKED);
    add(0, 8'hFF, 0, 1, 0, E2, ST_LOCKED);
    add(1, 8'h8E, 0, 1, 0, E2, ST_LOCKED);
    // Clear, then three 1-bit-wrong words lose lock.
    add(0, 8'h00, 1, 1, 0, 0,  ST_LOCKED);
    add(1, 8'h1D, 0, 1, 1, 1,  ST_LOCKED);
    add(1, 8'h39, 0, 1, 1, 2,  ST_LOCKED);
    add(1, 8'h70, 0, 0, 1, 3,  ST_HUNT);
    add(0, 8'h00, 0, 0, 0, 3,  ST_HUNT);
    // The lockup word never seeds.
    for (int i = 0; i < 20; i++) add(1, 8'h00, 0, 0, 0, 3, ST_HUNT);
    // Relock, reach count 2, then clear on the same beat as an error.
    add(0, 8'h00, 1, 0, 0, 0,  ST_HUNT);
    add(1, 8'h01, 0, 0, 0, 0,  ST_VERIFY);
    add(1, 8'h02, 0, 0, 0, 0,  ST_VERIFY);
    add(1, 8'h04, 0, 0, 0, 0,  ST_VERIFY);
    add(1, 8'h08, 0, 0, 0, 0,  ST_VERIFY);
    add(1, 8'h11, 0, 1, 0, 0,  ST_LOCKED);
    add(1, 8'h22, 0, 1, 1, 1,  ST_LOCKED);
    add(1, 8'h47, 0, 1, 0, 1,  ST_LOCKED);
    add(1, 8'h8F, 0, 1, 1, 2,  ST_LOCKED);
    add(1, 8'h1D, 1, 1, 1, 0,  ST_LOCKED);
    add(1, 8'h38, 0, 1, 0, 0,  ST_LOCKED);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, ST_HUNT);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].exp_locked, vecs[i].exp_pulse,
                       vecs[i].exp_state, vecs[i].exp_count});
      beat(vecs[i].valid, vecs[i].bits, vecs[i].clear);
      e = exp_q.pop_front();
      check_all($sformatf("vec%0d", i), e[19], e[18], e[15:0], e[17:16]);
    end

    // Saturation: alternate 1-bit errors and correct words so lock holds.
    p = 8'h71;
    k = 16'd0;
    for (int i = 0; i < 18; i++) begin
      beat(1'b1, p ^ 8'h01, 1'b0);
      p = nx(p);
      k = k + 16'd1;
      check_all($sformatf("sat%0d_err", i), 1, 1, k, ST_LOCKED);
      beat(1'b1, p, 1'b0);
      p = nx(p);
      check_all($sformatf("sat%0d_ok", i), 1, 0, k, ST_LOCKED);
    end

    // Reset while LOCKED with a nonzero count and a mismatching beat present.
    reset_beat(1'b1, p ^ 8'hFF);
    check_all("rst_locked", 0, 0, 0, ST_HUNT);
    @(negedge clk);
    rst = 1'b0;

    // Reset while in VERIFY.
    beat(1'b1, 8'h01, 1'b0);
    check_all("pre_rst_v0", 0, 0, 0, ST_VERIFY);
    beat(1'b1, 8'h02, 1'b0);
    check_all("pre_rst_v1", 0, 0, 0, ST_VERIFY);
    reset_beat(1'b1, 8'h04);
    check_all("rst_verify", 0, 0, 0, ST_HUNT);
    @(negedge clk);
    rst = 1'b0;
    beat(1'b1, 8'h04, 1'b0);
    check_all("post_rst", 0, 0, 0, ST_VERIFY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
